// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall/flush sequencer.
package pipeline_stall_ctrl_pkg;

    localparam int   STALL_WAIT_CNT_LEN = 8;
    localparam logic ZERO               = 1'b0;
    localparam logic ONE                = 1'b1;

    typedef enum logic [1:0] {
        STALL_ST_RUN      = 2'd0,
        STALL_ST_MEM_WAIT = 2'd1,
        STALL_ST_FAULT    = 2'd2
    } stall_state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/branch/SRAM inputs and per-stage control outputs of the stall sequencer.
interface pipeline_stall_ctrl_if;

    logic hazard;
    logic branch_taken;
    logic mem_req;
    logic sram_ready;
    logic clr_fault;

    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_exe;
    logic flush_if_id;
    logic freeze_back;
    logic fault;

    // master drives the pipeline status, slave is the stall controller
    modport master (
        output hazard, branch_taken, mem_req, sram_ready, clr_fault,
        input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back, fault
    );

    modport slave (
        input  hazard, branch_taken, mem_req, sram_ready, clr_fault,
        output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back, fault
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with SRAM wait tracking and timeout fault.
// Define STALL_PERF_EN to add saturating stall/flush/mem-wait performance counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_stall_ctrl_if.slave bus
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output logic [CNT_W-1:0]     flush_count_o,
    output logic [CNT_W-1:0]     mem_wait_cycles_o
`endif
);

    localparam logic [STALL_WAIT_CNT_LEN-1:0] WaitLast = STALL_WAIT_CNT_LEN'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("pipeline_stall_ctrl: MEM_TIMEOUT must be 2..255 and CNT_W at least 1");
    end

    stall_state_e                  state_q;
    stall_state_e                  state_d;
    logic [STALL_WAIT_CNT_LEN-1:0] wait_cnt_q;
    logic [STALL_WAIT_CNT_LEN-1:0] wait_cnt_d;

    logic mem_stall;
    logic freeze_pc;
    logic freeze_if_id;
    logic bubble_id_exe;
    logic flush_if_id;
    logic freeze_back;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STALL_ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // sram_ready is tested before the timeout so a completion on the last allowed cycle wins
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            STALL_ST_RUN: begin
                if (bus.mem_req && !bus.sram_ready) begin
                    state_d    = STALL_ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            STALL_ST_MEM_WAIT: begin
                wait_cnt_d = wait_cnt_q + STALL_WAIT_CNT_LEN'(1);
                if (bus.sram_ready) begin
                    state_d = STALL_ST_RUN;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d = STALL_ST_FAULT;
                end
            end
            STALL_ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = STALL_ST_RUN;
                end
            end
            default: state_d = STALL_ST_RUN;
        endcase
    end

    // A memory stall freezes ID and EXE, so a pending branch or hazard is simply held
    always_comb begin
        mem_stall     = (bus.mem_req & ~bus.sram_ready) | (state_q == STALL_ST_FAULT);
        freeze_pc     = ZERO;
        freeze_if_id  = ZERO;
        bubble_id_exe = ZERO;
        flush_if_id   = ZERO;
        freeze_back   = ZERO;
        if (mem_stall) begin
            freeze_pc    = ONE;
            freeze_if_id = ONE;
            freeze_back  = ONE;
        end else if (bus.branch_taken) begin
            flush_if_id   = ONE;
            bubble_id_exe = ONE;
        end else if (bus.hazard) begin
            freeze_pc     = ONE;
            freeze_if_id  = ONE;
            bubble_id_exe = ONE;
        end
    end

    assign bus.freeze_pc     = freeze_pc;
    assign bus.freeze_if_id  = freeze_if_id;
    assign bus.bubble_id_exe = bubble_id_exe;
    assign bus.flush_if_id   = flush_if_id;
    assign bus.freeze_back   = freeze_back;
    assign bus.fault         = (state_q == STALL_ST_FAULT);

`ifdef STALL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (freeze_pc & ~flush_if_id),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (flush_if_id),
        .count_o (flush_count_o)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (freeze_back),
        .count_o (mem_wait_cycles_o)
    );
`else
    // Counter build disabled: control outputs are unaffected.
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl with MEM_TIMEOUT=4.
module tb_pipeline_stall_ctrl;

    localparam int CntW = 16;

    // {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back, fault}
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] HAZ  = 6'b111000;
    localparam logic [5:0] BR   = 6'b001100;
    localparam logic [5:0] MEM  = 6'b110010;
    localparam logic [5:0] FLT  = 6'b110011;

    typedef struct {
        logic [5:0] ctl;
        string      tag;
        bit         clrModel;
    } exp_t;

    logic clk;
    logic rst_n;
    pipeline_stall_ctrl_if bus();

`ifdef STALL_PERF_EN
    logic [CntW-1:0] stallCycles;
    logic [CntW-1:0] flushCount;
    logic [CntW-1:0] memWaitCycles;
`endif

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles_o    (stallCycles),
        .flush_count_o     (flushCount),
        .mem_wait_cycles_o (memWaitCycles)
`endif
    );

    exp_t expQ[$];
    exp_t cur;
    int   checks;
    int   failures;
    int   modelStall;
    int   modelFlush;
    int   modelWait;
    bit   stimDone;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic hz, input logic br, input logic mr, input logic rdy, input logic clr);
        bus.hazard       = hz;
        bus.branch_taken = br;
        bus.mem_req      = mr;
        bus.sram_ready   = rdy;
        bus.clr_fault    = clr;
    endtask

    task automatic applyStimulus(input logic hz, input logic br, input logic mr, input logic rdy,
                                 input logic clr, input logic [5:0] ctl, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(hz, br, mr, rdy, clr);
        e.ctl      = ctl;
        e.tag      = tag;
        e.clrModel = 1'b0;
        expQ.push_back(e);
    endtask

    // Asserts reset just after an edge; pulse=1 releases it again before the next edge
    task automatic applyReset(input logic hz, input logic br, input logic mr, input logic rdy,
                              input logic [5:0] ctl, input string tag, input bit pulse);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(hz, br, mr, rdy, 1'b0);
        rst_n = 1'b0;
        e.ctl      = ctl;
        e.tag      = tag;
        e.clrModel = 1'b1;
        expQ.push_back(e);
        if (pulse) begin
            #2;
            rst_n = 1'b1;
        end
    endtask

    initial begin : stimulus
        rst_n    = 1'b0;
        stimDone = 1'b0;
        driveInputs(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, IDLE, "reset_idle");
        applyStimulus(1, 0, 0, 0, 0, HAZ,  "hazard_c1");
        applyStimulus(1, 0, 0, 0, 0, HAZ,  "hazard_c2");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "hazard_end");
        applyStimulus(1, 1, 0, 0, 0, BR,   "branch_with_hazard");
        applyStimulus(0, 1, 0, 0, 0, BR,   "branch_only");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "branch_end");

        applyStimulus(0, 0, 1, 0, 0, MEM,  "sram_wait_c1");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "sram_wait_c2");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "sram_wait_c3");
        applyStimulus(0, 0, 1, 1, 0, IDLE, "sram_ready_cycle");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "sram_done");
        applyStimulus(0, 0, 1, 1, 0, IDLE, "sram_immediate");
        applyStimulus(1, 0, 1, 0, 0, MEM,  "hazard_under_wait");
        applyStimulus(1, 0, 1, 1, 0, HAZ,  "hazard_after_wait");

        applyStimulus(0, 1, 1, 0, 0, MEM,  "branch_wait_c1");
        applyStimulus(0, 1, 1, 0, 0, MEM,  "branch_wait_c2");
        applyStimulus(0, 1, 1, 1, 0, BR,   "branch_wait_ready");
        applyStimulus(0, 0, 0, 0, 1, IDLE, "clr_fault_in_run");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "clr_fault_no_effect");

        applyStimulus(0, 0, 1, 0, 0, MEM,  "timeout_c0");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "timeout_c1");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "timeout_c2");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "timeout_c3");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "timeout_last_wait");
        applyStimulus(0, 0, 1, 0, 0, FLT,  "fault_entered");
        applyStimulus(1, 1, 0, 1, 0, FLT,  "fault_ignores_inputs");
        applyStimulus(0, 0, 0, 0, 0, FLT,  "fault_held");
        applyStimulus(0, 0, 0, 0, 1, FLT,  "fault_clr_cycle");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "fault_cleared");

        applyStimulus(0, 0, 1, 0, 0, MEM,  "race_c0");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "race_c1");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "race_c2");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "race_c3");
        applyStimulus(0, 0, 1, 1, 0, IDLE, "race_ready_at_limit");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "race_no_fault");

        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_c0");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_c1");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_c2");
        applyReset   (0, 0, 1, 0, MEM,     "rstwait_pulse", 1'b1);
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_restart_c1");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_restart_c2");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_restart_c3");
        applyStimulus(0, 0, 1, 0, 0, MEM,  "rstwait_restart_c4");
        applyStimulus(0, 0, 1, 0, 0, FLT,  "rstwait_fault");
        applyStimulus(0, 0, 0, 0, 0, FLT,  "rstwait_fault_held");
        applyReset   (0, 0, 0, 0, IDLE,    "async_reset_from_fault", 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, IDLE, "after_reset_idle");
        applyStimulus(1, 0, 0, 0, 0, HAZ,  "after_reset_hazard");
        applyStimulus(0, 1, 0, 0, 0, BR,   "after_reset_branch");
        applyStimulus(0, 0, 0, 0, 0, IDLE, "final_idle");
        stimDone = 1'b1;
    end

    // Monitor: compares every queued expectation on the falling edge and owns the summary
    initial begin : monitor
        int cycles;
        checks     = 0;
        failures   = 0;
        modelStall = 0;
        modelFlush = 0;
        modelWait  = 0;
        cycles     = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (expQ.size() > 0) begin
                cur = expQ.pop_front();
                if (cur.clrModel) begin
                    modelStall = 0;
                    modelFlush = 0;
                    modelWait  = 0;
                end
                checkOutput(cur.tag,
                            {26'd0, bus.freeze_pc, bus.freeze_if_id, bus.bubble_id_exe,
                             bus.flush_if_id, bus.freeze_back, bus.fault},
                            {26'd0, cur.ctl});
                if (cur.ctl[5] && !cur.ctl[2]) modelStall++;
                if (cur.ctl[2]) modelFlush++;
                if (cur.ctl[1]) modelWait++;
            end else if (stimDone) begin
`ifdef STALL_PERF_EN
                checkOutput("stall_cycles",    32'(stallCycles),   32'(modelStall));
                checkOutput("flush_count",     32'(flushCount),    32'(modelFlush));
                checkOutput("mem_wait_cycles", 32'(memWaitCycles), 32'(modelWait));
`endif
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (cycles > 2000) begin
                failures++;
                $display("[TB] FAIL watchdog actual=%0d cycles required=completion", cycles);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. Combines the hazard detector's `hazard` flag, the EXE-stage taken-branch flag and the MEM-stage SRAM handshake into per-stage freeze, bubble and flush controls. A small FSM tracks outstanding SRAM accesses, enforces a timeout, and latches a fault state that halts the pipeline. The block sits between the hazard detection logic, the SRAM controller and the pipeline registers.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: the maximum number of MEM_WAIT cycles before a fault is raised. Legal range is 2..255.
- `CNT_W`, default 32: the width of the performance counters.

Ports:
- `clk` input 1: pipeline clock. All state updates on the rising edge.
- `rst_n` input 1: reset. Asynchronous assertion, active-low. One clock, one reset.
- `hazard` input 1: RAW hazard from the hazard detector, for the instruction in ID.
- `branch_taken` input 1: the instruction in EXE redirects the PC.
- `mem_req` input 1: the MEM-stage instruction performs a load or store.
- `sram_ready` input 1: the SRAM access completes this cycle.
- `clr_fault` input 1: synchronous fault clear.
- `freeze_pc` output 1: hold the PC register.
- `freeze_if_id` output 1: hold the IF/ID register.
- `bubble_id_exe` output 1: load a NOP into ID/EXE.
- `flush_if_id` output 1: clear the IF/ID register.
- `freeze_back` output 1: hold the ID/EXE, EXE/MEM and MEM/WB registers.
- `fault` output 1: the controller is in the FAULT state.
- `stall_cycles`, `flush_count`, `mem_wait_cycles` output CNT_W each: present only with STALL_PERF_EN.

## Operation
The FSM has three states:
- RUN is the reset state.
- MEM_WAIT means an SRAM access is outstanding.
- FAULT means an SRAM access timed out.

State transitions:
- RUN → MEM_WAIT when `mem_req & ~sram_ready`.
- MEM_WAIT → RUN when `sram_ready`.
- MEM_WAIT → FAULT when `wait_cnt == MEM_TIMEOUT-1 & ~sram_ready`.
- FAULT → RUN on `clr_fault`. All other input combinations are ignored while in FAULT.

`wait_cnt` is 8 bits wide:
- It is cleared on entry to MEM_WAIT.
- It increments each cycle spent in MEM_WAIT.
- It holds its value in the other states.

Output logic is Mealy (state plus inputs). Priority, highest first:
1. Memory wait. `mem_stall = (mem_req & ~sram_ready) | (state==FAULT)`. When it is active: `freeze_pc`, `freeze_if_id` and `freeze_back` are 1; `bubble_id_exe` and `flush_if_id` are 0. A branch or hazard is held, not lost, because EXE and ID are frozen.
2. Branch. `branch_taken & ~mem_stall` drives `flush_if_id=1` and `bubble_id_exe=1`. `freeze_pc=0`, so the target PC loads. `hazard` is ignored, since the ID instruction is squashed.
3. Hazard. `hazard & ~mem_stall & ~branch_taken` drives `freeze_pc=1`, `freeze_if_id=1` and `bubble_id_exe=1`.
4. Otherwise all control outputs are 0.

`freeze_back` is never asserted by a hazard or a branch.

## Timing
- All control outputs are combinational, with zero latency from their inputs in the same cycle.
- Reset values: state is RUN and `wait_cnt` is 0, so `fault=0`. All counters are 0. Control outputs then follow their inputs.
- SRAM handshake:
  - The access issued in cycle N completes in the first cycle M ≥ N with `sram_ready=1`.
  - `freeze_back` is high for cycles N..M-1 and low in cycle M.
  - If `sram_ready=1` in cycle N, the state stays RUN and there is no stall.
- The timeout fires after exactly MEM_TIMEOUT consecutive not-ready cycles. FAULT is registered on the next edge.
- Simultaneous `sram_ready` and `wait_cnt==MEM_TIMEOUT-1`: `sram_ready` wins, and the next state is RUN.
- `clr_fault` in any state other than FAULT has no effect.
- Reset mid-wait returns the state to RUN immediately, asynchronously. A `mem_req` still high after reset restarts the wait.

## Configuration
- With `STALL_PERF_EN` defined, three saturating counters of CNT_W bits each are instantiated. Each stops at all-ones and each is cleared by reset only:
  - `stall_cycles` increments on cycles with `freeze_pc & ~flush_if_id`.
  - `flush_count` increments on cycles with `flush_if_id`.
  - `mem_wait_cycles` increments on cycles with `freeze_back`.
- Without `STALL_PERF_EN`, the counter ports and logic are absent. Control behaviour is identical in both builds.

## Structure
- The following go in Constants.v:
  - state encodings `STALL_ST_RUN`, `STALL_ST_MEM_WAIT`, `STALL_ST_FAULT` (2 bits);
  - `STALL_WAIT_CNT_LEN` = 8;
  - the existing `ZERO` and `ONE` constants.
- One sub-module, `sat_counter`, parameterised by width, with enable input, asynchronous active-low reset and saturation. It is instantiated three times under the macro.

## Test plan
- **Hazard only.** `hazard=1` for 2 cycles, no `mem_req`. Expect `freeze_pc`, `freeze_if_id` and `bubble_id_exe` high for exactly 2 cycles, `flush_if_id=0` and `freeze_back=0`. With the macro, `stall_cycles` is 2.
- **Branch with hazard.** `branch_taken=1` and `hazard=1` in the same cycle. Expect `flush_if_id=1`, `bubble_id_exe=1`, `freeze_pc=0`. With the macro, `flush_count` is 1.
- **SRAM wait.** `mem_req=1` with `sram_ready` rising after 3 cycles. Expect `freeze_back` high for 3 cycles and low in the ready cycle. The state is MEM_WAIT for 3 cycles, then RUN. With the macro, `mem_wait_cycles` is 3.
- **Branch during wait.** `branch_taken=1` during the SRAM wait. Expect no flush until the cycle `sram_ready=1`, and the flush in that same cycle.
- **Timeout.** With `MEM_TIMEOUT=4`, `mem_req=1` and `sram_ready=0`. Expect `fault=1` from the 5th edge, with all freezes held. `clr_fault` returns the state to RUN. In a second run, `sram_ready` arriving together with `wait_cnt=3` leaves `fault=0`.
- **Reset mid-wait.** Drop `rst_n` mid-MEM_WAIT. Expect the state to return to RUN and `fault=0` immediately, before the next clock edge, with the counters cleared.
